// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Sequences an external 2-bit (x,y) Moore sequence detector. A packed word
//   of NUM_SYM symbol pairs is accepted on a valid/ready handshake and fed one
//   pair per clock. The detector's z output is sampled one cycle later and
//   tallied into per-word hit counts: pattern A (z=10) and pattern B (z=11).
//   The index of the symbol that completes the first hit is also captured.
//   The detector is held in reset between words, so each word is scored
//   independently.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     in_valid/ready  word handshake (ready only while idle)
//     sym_word        symbol k at [2k+1:2k], x = bit 2k+1, y = bit 2k
//     det_rst/x/y     detector drive (det_rst is combinational)
//     det_z           detector Moore output for the previous symbol
//     busy, done      word in progress / one-cycle results-valid pulse
//     hit_a, hit_b    saturating hit counts for the last word
//     first_hit_vld   at least one hit in the word
//     first_hit_idx   symbol index completing the first hit
//
//   Optional build macro SEQ_DETECT_CTRL_ABORT_EN adds:
//     abort   (in)  drop the current word while feeding or draining
//     aborted (out) one-cycle pulse when a word was dropped

module seq_detect_ctrl #(
  parameter  int NUM_SYM = 8,
  parameter  int CNT_W   = 4,
  localparam int IDX_W   = $clog2(NUM_SYM)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SEQ_DETECT_CTRL_ABORT_EN
  input  logic                 abort,
  output logic                 aborted,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*NUM_SYM-1:0] sym_word,
  output logic                 det_rst,
  output logic                 det_x,
  output logic                 det_y,
  input  logic [1:0]           det_z,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     hit_a,
  output logic [CNT_W-1:0]     hit_b,
  output logic                 first_hit_vld,
  output logic [IDX_W-1:0]     first_hit_idx
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t                      r_state;
  logic [NUM_SYM-1:0][1:0]     r_word;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_sv;     // det_z this cycle belongs to r_sidx
  logic [IDX_W-1:0]            r_sidx;
  logic [CNT_W-1:0]            r_hit_a;
  logic [CNT_W-1:0]            r_hit_b;
  logic                        r_fvld;
  logic [IDX_W-1:0]            r_fidx;
  logic                        r_in_ready;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_aborted;

  logic                        w_feed;
  logic                        w_abort;
  logic [1:0]                  w_sym;
  logic                        w_hit_a;
  logic                        w_hit_b;

  assign w_feed = (r_state == S_FEED);

`ifdef SEQ_DETECT_CTRL_ABORT_EN
  // Abort only matters while a word is in flight; idle/done ignore it.
  assign w_abort = abort && (r_state == S_FEED || r_state == S_DRAIN);
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  assign w_sym   = r_word[r_idx];
  assign w_hit_a = r_sv && (det_z == 2'b10);
  assign w_hit_b = r_sv && (det_z == 2'b11);

  // Detector is reset whenever it is not being fed, so symbol 0 always
  // meets a freshly initialised detector.
  assign det_rst = rst || !w_feed || w_abort;
  assign det_x   = w_feed ? w_sym[1] : 1'b0;
  assign det_y   = w_feed ? w_sym[0] : 1'b0;

  assign in_ready      = r_in_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign hit_a         = r_hit_a;
  assign hit_b         = r_hit_b;
  assign first_hit_vld = r_fvld;
  assign first_hit_idx = r_fidx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_idx      <= '0;
      r_sv       <= 1'b0;
      r_sidx     <= '0;
      r_hit_a    <= '0;
      r_hit_b    <= '0;
      r_fvld     <= 1'b0;
      r_fidx     <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_sv      <= 1'b0;

      // Tally the sample for the symbol fed last cycle (saturating).
      if (w_hit_a && r_hit_a != '1) r_hit_a <= r_hit_a + 1'b1;
      if (w_hit_b && r_hit_b != '1) r_hit_b <= r_hit_b + 1'b1;
      if ((w_hit_a || w_hit_b) && !r_fvld) begin
        r_fvld <= 1'b1;
        r_fidx <= r_sidx;
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_word     <= sym_word;
            r_idx      <= '0;
            r_hit_a    <= '0;
            r_hit_b    <= '0;
            r_fvld     <= 1'b0;
            r_fidx     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_FEED;
          end
        end
        S_FEED: begin
          if (w_abort) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_aborted  <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_sv   <= 1'b1;
            r_sidx <= r_idx;
            if (r_idx == IDX_W'(NUM_SYM - 1)) r_state <= S_DRAIN;
            else                              r_idx   <= r_idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_abort) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_aborted  <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // NUM_SYM=8 instance
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] sym_word = '0;
  logic        det_rst, det_x, det_y;
  logic [1:0]  det_z;
  logic        busy, done, fvld;
  logic [3:0]  hit_a, hit_b;
  logic [2:0]  fidx;
  // NUM_SYM=12 instances: u12 (CNT_W=4) and us (CNT_W=1, saturation)
  logic        in_valid12 = 1'b0, in_ready12, in_readys;
  logic [23:0] sym12 = '0;
  logic        det_rst12, x12, y12, det_rsts, xs, ys;
  logic [1:0]  z12, zs;
  logic        busy12, done12, fvld12, busys, dones, fvlds;
  logic [3:0]  ha12, hb12, fidx12, fidxs;
  logic [0:0]  has, hbs;
`ifdef SEQ_DETECT_CTRL_ABORT_EN
  logic abort = 1'b0, aborted, aborted12, aborteds;
`endif

  seq_detect_ctrl #(.NUM_SYM(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
`ifdef SEQ_DETECT_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .sym_word(sym_word),
    .det_rst(det_rst), .det_x(det_x), .det_y(det_y), .det_z(det_z),
    .busy(busy), .done(done), .hit_a(hit_a), .hit_b(hit_b),
    .first_hit_vld(fvld), .first_hit_idx(fidx));

  seq_detect_ctrl #(.NUM_SYM(12), .CNT_W(4)) u12 (
    .clk(clk), .rst(rst),
`ifdef SEQ_DETECT_CTRL_ABORT_EN
    .abort(1'b0), .aborted(aborted12),
`endif
    .in_valid(in_valid12), .in_ready(in_ready12), .sym_word(sym12),
    .det_rst(det_rst12), .det_x(x12), .det_y(y12), .det_z(z12),
    .busy(busy12), .done(done12), .hit_a(ha12), .hit_b(hb12),
    .first_hit_vld(fvld12), .first_hit_idx(fidx12));

  seq_detect_ctrl #(.NUM_SYM(12), .CNT_W(1)) us (
    .clk(clk), .rst(rst),
`ifdef SEQ_DETECT_CTRL_ABORT_EN
    .abort(1'b0), .aborted(aborteds),
`endif
    .in_valid(in_valid12), .in_ready(in_readys), .sym_word(sym12),
    .det_rst(det_rsts), .det_x(xs), .det_y(ys), .det_z(zs),
    .busy(busys), .done(dones), .hit_a(has), .hit_b(hbs),
    .first_hit_vld(fvlds), .first_hit_idx(fidxs));

  // Detector model: last four symbols since reset, oldest in the top bits.
  // A = 10,00,01,11 -> z=10 ; B = 01,00,10,11 -> z=11 ; Moore output.
  localparam logic [7:0] PAT_A = 8'b10_00_01_11;
  localparam logic [7:0] PAT_B = 8'b01_00_10_11;

  function automatic logic [1:0] zof(input logic [7:0] h, input int c);
    if (c < 4)       return 2'b00;
    if (h == PAT_A)  return 2'b10;
    if (h == PAT_B)  return 2'b11;
    return 2'b00;
  endfunction

  logic [7:0] h8 = '0, h12 = '0, hs = '0;
  int c8 = 0, c12 = 0, cs = 0;
  always @(posedge clk) begin
    if (det_rst) begin h8 <= '0; c8 <= 0; end
    else begin h8 <= {h8[5:0], det_x, det_y}; if (c8 < 4) c8 <= c8 + 1; end
    if (det_rst12) begin h12 <= '0; c12 <= 0; end
    else begin h12 <= {h12[5:0], x12, y12}; if (c12 < 4) c12 <= c12 + 1; end
    if (det_rsts) begin hs <= '0; cs <= 0; end
    else begin hs <= {hs[5:0], xs, ys}; if (cs < 4) cs <= cs + 1; end
  end
  assign det_z = zof(h8, c8);
  assign z12   = zof(h12, c12);
  assign zs    = zof(hs, cs);

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference scoring: slide a 4-symbol window across the word.
  function automatic void ref_word(input logic [23:0] w, input int n,
                                   output int ha, output int hb,
                                   output int fv, output int fi);
    logic [7:0] win;
    ha = 0; hb = 0; fv = 0; fi = 0;
    for (int k = 3; k < n; k++) begin
      win = {w[2*(k-3)+:2], w[2*(k-2)+:2], w[2*(k-1)+:2], w[2*k+:2]};
      if (win == PAT_A || win == PAT_B) begin
        if (win == PAT_A) ha++; else hb++;
        if (fv == 0) begin fv = 1; fi = k; end
      end
    end
  endfunction

  // Literals are written symbol 0 first (leftmost); convert to port packing.
  function automatic logic [15:0] rev8(input logic [15:0] l);
    logic [15:0] r;
    for (int k = 0; k < 8; k++) r[2*k+:2] = l[2*(7-k)+:2];
    return r;
  endfunction
  function automatic logic [23:0] rev12(input logic [23:0] l);
    logic [23:0] r;
    for (int k = 0; k < 12; k++) r[2*k+:2] = l[2*(11-k)+:2];
    return r;
  endfunction

  // Submit one word to the 8-symbol instance and wait for done.
  task automatic run8(input logic [15:0] w, output int lat, output int seq_ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("idle_det_rst", int'(det_rst), 1);
    in_valid = 1'b1; sym_word = w;
    @(posedge clk); #1;
    in_valid = 1'b0; sym_word = $urandom;
    lat = 0; seq_ok = 1;
    do begin
      @(negedge clk); lat++;
      if (lat <= 8) begin
        if (det_rst !== 1'b0 || {det_x, det_y} !== w[2*(lat-1)+:2] ||
            busy !== 1'b1 || in_ready !== 1'b0) seq_ok = 0;
      end else if (det_rst !== 1'b1 || det_x !== 1'b0 || det_y !== 1'b0 ||
                   busy !== 1'b1) seq_ok = 0;
    end while (!done && lat < 30);
  endtask

  typedef struct {
    logic [15:0] lit;
    int ha, hb, vld, idx;
  } vec_t;
  vec_t tv[6];

  initial begin
    int lat, ok, ha, hb, fv, fi, prev, ndone, nodone, accw;
    logic [15:0] w;
    logic [7:0] pat;
    int p;

    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, ok, ha, hb, fv, fi, prev, ndone, nodone;
    logic [15:0] w, accw;
    logic [7:0] pat;
    int p;

    tv[0] = '{16'b00_01_11_10_00_01_11_00, 1, 0, 1, 6};
    tv[1] = '{16'b00_10_11_01_00_10_11_00, 0, 1, 1, 6};
    tv[2] = '{16'b00_00_00_00_00_01_11_10, 0, 0, 0, 0};
    tv[3] = '{16'b00_01_11_00_00_00_00_00, 0, 0, 0, 0};
    tv[4] = '{16'b10_00_01_11_01_00_10_11, 1, 1, 1, 3};
    tv[5] = '{16'b00_00_00_00_10_00_01_11, 1, 0, 1, 7};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hits", int'({hit_a, hit_b}), 0);
    chk("rst_first", int'({fvld, fidx}), 0);
    chk("rst_det", int'({det_rst, det_x, det_y}), 3'b100);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven directed words
    for (int i = 0; i < 6; i++) begin
      run8(rev8(tv[i].lit), lat, ok);
      chk($sformatf("v%0d_latency", i), lat, 10);
      chk($sformatf("v%0d_feed", i), ok, 1);
      chk($sformatf("v%0d_hit_a", i), int'(hit_a), tv[i].ha);
      chk($sformatf("v%0d_hit_b", i), int'(hit_b), tv[i].hb);
      chk($sformatf("v%0d_vld", i), int'(fvld), tv[i].vld);
      chk($sformatf("v%0d_idx", i), int'(fidx), tv[i].idx);
    end

    // Results hold in idle
    run8(rev8(tv[0].lit), lat, ok);
    repeat (3) @(negedge clk);
    chk("hold_hit_a", int'(hit_a), 1);
    chk("hold_first", int'({fvld, fidx}), 4'b1_110);
    chk("hold_done_low", int'(done), 0);

    // in_valid held high with sym_word changing every cycle
    prev = -1; ndone = 0; ok = 1; accw = '0;
    sym_word = $urandom; in_valid = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        ref_word({8'b0, accw}, 8, ha, hb, fv, fi);
        chk("cont_hit_a", int'(hit_a), ha);
        chk("cont_hit_b", int'(hit_b), hb);
        chk("cont_first", int'({fvld, fidx}), fv * 8 + fi);
      end
      if (busy && in_ready) ok = 0;
      if (in_ready) begin
        if (prev >= 0) chk("cont_spacing", cyc - prev, 11);
        prev = cyc; accw = sym_word;
      end
      @(posedge clk); #1 sym_word = $urandom;
    end
    in_valid = 1'b0;
    chk("cont_ready_vs_busy", ok, 1);
    chk("cont_done_count", int'(ndone >= 3), 1);
    p = 0;
    while (!in_ready && p < 20) begin @(negedge clk); p++; end

    // rst during FEED idx 3
    @(negedge clk);
    in_valid = 1'b1; sym_word = rev8(tv[0].lit);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_hits", int'({hit_a, fvld}), 0);
    chk("midrst_det_rst", int'(det_rst), 1);
    nodone = 1;
    repeat (12) begin @(negedge clk); if (done) nodone = 0; end
    chk("midrst_no_done", nodone, 1);
    run8(rev8(tv[0].lit), lat, ok);
    chk("after_rst_latency", lat, 10);
    chk("after_rst_hit_a", int'(hit_a), 1);
    chk("after_rst_idx", int'({fvld, fidx}), 4'b1_110);

    // Randomised words, many with a planted pattern
    for (int r = 0; r < 40; r++) begin
      w = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        p = $urandom_range(3, 7);
        pat = ($urandom_range(0, 1) != 0) ? PAT_A : PAT_B;
        w[2*(p-3)+:2] = pat[7:6]; w[2*(p-2)+:2] = pat[5:4];
        w[2*(p-1)+:2] = pat[3:2]; w[2*p+:2]     = pat[1:0];
      end
      ref_word({8'b0, w}, 8, ha, hb, fv, fi);
      run8(w, lat, ok);
      chk("rnd_latency", lat, 10);
      chk("rnd_feed", ok, 1);
      chk("rnd_hit_a", int'(hit_a), ha);
      chk("rnd_hit_b", int'(hit_b), hb);
      chk("rnd_first", int'({fvld, fidx}), fv * 8 + fi);
    end

    // NUM_SYM=12: overlapping A hits; CNT_W=1 copy saturates
    @(negedge clk);
    in_valid12 = 1'b1;
    sym12 = rev12(24'b00_01_11_10_00_01_11_10_00_01_11_00);
    @(posedge clk); #1 in_valid12 = 1'b0; sym12 = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done12 && lat < 40);
    chk("n12_latency", lat, 14);
    chk("n12_hit_a", int'(ha12), 2);
    chk("n12_hit_b", int'(hb12), 0);
    chk("n12_first", int'({fvld12, fidx12}), 5'b1_0110);
    chk("sat_done", int'(dones), 1);
    chk("sat_hit_a", int'(has), 1);
    chk("sat_first", int'({fvlds, fidxs}), 5'b1_0110);

`ifdef SEQ_DETECT_CTRL_ABORT_EN
    // Abort after the idx-3 hit of tv[4] has been tallied
    @(negedge clk);
    in_valid = 1'b1; sym_word = rev8(tv[4].lit);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_pulse", int'(aborted), 1);
    chk("abort_idle", int'({in_ready, busy, det_rst}), 3'b101);
    chk("abort_partial", int'(hit_a), 1);
    nodone = 1;
    repeat (12) begin @(negedge clk); if (done) nodone = 0; end
    chk("abort_no_done", nodone, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
